photobooth_rom_arbiter: RTL
===========================

# photobooth_rom_arbiter

Shares one single-port image BROM (8-bit palette indices, registered output) between two readers. The primary reader is the pixel pipeline, which needs one address per pixel clock and a fixed latency. The auxiliary reader is a background agent, such as a thumbnail or frame-dump engine, that uses a req/ack handshake. The block sits between the sprite renderer's address calculation and the BROM, so the photobooth image can be read out while it is on screen.

## Interface
Parameters:
- ADDR_W, default 17: ROM address width. Covers 800*128 = 102400 entries.
- DATA_W, default 8: ROM data width, one palette index.
- ROM_LATENCY, default 2: BROM read latency in cycles. 2 is the HIGH_PERFORMANCE setting. Legal range 1..4.
- STARVE_LIMIT, default 1023: count of consecutive ungranted aux-request cycles that raises the starvation flag.

Ports:
- pixel_clk_in, input, 1: the single clock.
- rst_in, input, 1: asynchronous, active-high reset.
- vid_valid_in, input, 1: the pixel pipeline needs a read this cycle. High only when the pixel is inside the sprite.
- vid_addr_in, input, ADDR_W: the pixel pipeline's address.
- vid_valid_out, output, 1: vid_data_out holds a video read result.
- vid_data_out, output, DATA_W: video read data.
- aux_req_in, input, 1: aux read request. Held with its address until acked.
- aux_addr_in, input, ADDR_W: aux address.
- aux_ack_out, output, 1: the aux request was granted this cycle.
- aux_valid_out, output, 1: one-cycle pulse when aux_data_out is updated.
- aux_data_out, output, DATA_W: aux read data. Held until the next aux_valid_out.
- aux_starve_out, output, 1: sticky status flag; aux has been starved.
- rom_addr_out, output, ADDR_W: address to the BROM.
- rom_data_in, input, DATA_W: BROM output.

## Operation
- Priority is fixed: video always wins. Aux is granted only in cycles where vid_valid_in = 0 and aux_req_in = 1. The video path is never stalled or delayed.
- rom_addr_out is a combinational mux: vid_addr_in when vid_valid_in = 1, otherwise aux_addr_in. It is aux_addr_in even when idle.
- aux_ack_out is combinational and equals aux_req_in & ~vid_valid_in. The requester may change its address or drop its request in the cycle after the ack. Back-to-back aux grants are allowed, one per cycle.
- A tag shift register, ROM_LATENCY deep, carries two bits per grant slot: vid and aux. Each cycle a new entry is shifted in: {vid_valid_in, aux_ack_out}.
- vid_valid_out is the vid bit of the oldest tag.
- vid_data_out is rom_data_in passed through combinationally, gated to 0 when vid_valid_out = 0.
- When the oldest tag's aux bit is 1, aux_data_out is registered from rom_data_in and aux_valid_out pulses in the following cycle.
- Aux results return in grant order. Every ack produces exactly one aux_valid_out.
- Starvation counter:
  - Increments each cycle with aux_req_in = 1 and aux_ack_out = 0.
  - Clears on any ack, or when aux_req_in = 0.
  - Saturates at STARVE_LIMIT. Width is $clog2(STARVE_LIMIT+1).
  - aux_starve_out sets when the count reaches STARVE_LIMIT and stays set until reset.
  - It is status only; priority does not change.

## Timing
- Reset (asynchronous, active-high):
  - Tags cleared; in-flight reads are discarded, so no valid pulses occur after reset.
  - Starvation counter = 0.
  - vid_valid_out = 0, vid_data_out = 0, aux_valid_out = 0, aux_data_out = 0, aux_starve_out = 0.
  - aux_ack_out and rom_addr_out follow their inputs combinationally.
  - Deasserting reset in the middle of a frame is legal; the first grant after release is a normal grant.
- Video latency: address in cycle t gives vid_valid_out and data in cycle t+ROM_LATENCY. This matches a bare BROM, so the arbiter is a drop-in replacement.
- Aux latency: ack in cycle t gives aux_valid_out and aux_data_out in cycle t+ROM_LATENCY+1.
- When vid_valid_in rises in a cycle where aux_req_in is already high, there is no ack that cycle. The aux request stays pending and is granted in the first cycle with vid_valid_in = 0.
- When a video return and an aux return are in flight in adjacent slots, both are delivered. A slot never has both tag bits set.
- With aux_req_in = 0 and vid_valid_in = 0, the slot is empty and no output pulses.

## Test plan
- Video only: vid_valid_in = 1 for addresses 0..9, ROM models addr -> addr[7:0], LATENCY = 2. Expect vid_valid_out high for cycles 2..11 with data 0..9, aux_ack_out never high.
- Aux in idle: aux_req_in at addr 0x00123 with vid idle. Expect aux_ack_out in the same cycle, then aux_valid_out 3 cycles later with aux_data_out = 0x23 held afterwards.
- Interleave: vid_valid_in pattern 1,1,0,1,0,0 with aux_req_in continuously high, addresses incrementing on each ack. Expect acks exactly in cycles 2, 4 and 5, aux data returned in order, and video returns unaffected.
- Starvation: STARVE_LIMIT = 8, vid_valid_in held at 1 while aux_req_in = 1. Expect aux_starve_out to rise after 8 cycles, stay high, and the first ack to occur the cycle vid_valid_in drops.
- Reset mid-flight: grant a video read and an aux read, then assert rst_in one cycle later. Expect all outputs 0 immediately and no vid_valid_out or aux_valid_out after release until new grants are made.
- Latency sweep: repeat the video-only and aux-in-idle scenarios with ROM_LATENCY = 1 and ROM_LATENCY = 4. Latencies must be exactly LAT and LAT+1.

Source files
------------

// File: rtl/photobooth_rom_arbiter_if.sv
// Bus bundle between the photobooth BROM arbiter, its two readers and the BROM.
// The slave modport is the arbiter's view of the bus. The master modport is
// the environment's view: the readers plus the ROM.
interface photobooth_rom_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  // video reader
  logic              vid_valid_in;
  logic [ADDR_W-1:0] vid_addr_in;
  logic              vid_valid_out;
  logic [DATA_W-1:0] vid_data_out;
  // auxiliary reader
  logic              aux_req_in;
  logic [ADDR_W-1:0] aux_addr_in;
  logic              aux_ack_out;
  logic              aux_valid_out;
  logic [DATA_W-1:0] aux_data_out;
  logic              aux_starve_out;
  // BROM side
  logic [ADDR_W-1:0] rom_addr_out;
  logic [DATA_W-1:0] rom_data_in;

  modport slave (
    input  vid_valid_in, vid_addr_in, aux_req_in, aux_addr_in, rom_data_in,
    output vid_valid_out, vid_data_out, aux_ack_out, aux_valid_out,
           aux_data_out, aux_starve_out, rom_addr_out
  );

  modport master (
    output vid_valid_in, vid_addr_in, aux_req_in, aux_addr_in, rom_data_in,
    input  vid_valid_out, vid_data_out, aux_ack_out, aux_valid_out,
           aux_data_out, aux_starve_out, rom_addr_out
  );
endinterface

// File: rtl/photobooth_rom_arbiter.sv
// Shares one single-port BROM between the pixel pipeline and a background aux
// reader. Video has fixed priority and keeps bare-BROM latency. Aux uses
// req/ack, and its results come back one cycle later through a register.
// A small tag pipeline records who owns each in-flight read slot.
module photobooth_rom_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int ROM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  photobooth_rom_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                   ack;
  logic [ADDR_W-1:0]      addr_mux;
  // Slot ownership. Index 0 is the newest slot and ROM_LATENCY-1 is the oldest.
  logic [ROM_LATENCY-1:0] vid_pipe;
  logic [ROM_LATENCY-1:0] aux_pipe;
  logic                   aux_vld;
  logic [DATA_W-1:0]      aux_data;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   starve;

  // Aux gets the port only in cycles video leaves free. Video is never stalled.
  assign ack                = bus.aux_req_in & ~bus.vid_valid_in;
  assign addr_mux           = bus.vid_valid_in ? bus.vid_addr_in : bus.aux_addr_in;
  assign bus.aux_ack_out    = ack;
  assign bus.rom_addr_out   = addr_mux;

  // Video returns straight from the ROM port, so it has the same latency as a bare BROM.
  assign bus.vid_valid_out  = vid_pipe[ROM_LATENCY-1];
  assign bus.vid_data_out   = vid_pipe[ROM_LATENCY-1] ? bus.rom_data_in : {DATA_W{1'b0}};
  assign bus.aux_valid_out  = aux_vld;
  assign bus.aux_data_out   = aux_data;
  assign bus.aux_starve_out = starve;

  // Shift in this cycle's ownership. Reset clears all slots, which drops in-flight reads.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      vid_pipe <= '0;
      aux_pipe <= '0;
    end else begin
      vid_pipe <= ROM_LATENCY'({vid_pipe, bus.vid_valid_in});
      aux_pipe <= ROM_LATENCY'({aux_pipe, ack});
    end
  end

  // Capture the aux result. It is held until the next aux return.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      aux_vld  <= 1'b0;
      aux_data <= '0;
    end else begin
      aux_vld <= aux_pipe[ROM_LATENCY-1];
      if (aux_pipe[ROM_LATENCY-1]) aux_data <= bus.rom_data_in;
    end
  end

  // Count consecutive ungranted request cycles, saturating at the limit.
  always_comb begin
    cnt_next = cnt;
    if (!bus.aux_req_in || ack)
      cnt_next = '0;
    else if (cnt != LIMIT)
      cnt_next = cnt + CNT_W'(1);
  end

  // The starvation flag is sticky status only. It does not change arbitration.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == LIMIT) starve <= 1'b1;
    end
  end
endmodule
